ds2411_id_check: RTL and testbench

Supervisor stage directly downstream of the DS2411 serial-number reader. It pulses the reader's `go`, waits for the bus cycle to end, and retries on no-response. It then runs the Dallas CRC-8 over the 64-bit readback, optionally checks the family code, and presents a validated 48-bit board serial number with a status code. The reader's outputs come from its 1 MHz tick-derived clock and are resynchronised here.

---
 rtl/ds2411_id_check_if.sv | 33 +++
 rtl/ds2411_id_check.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_ds2411_id_check.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds2411_id_check_if.sv
// ---------------------------------------------------------------------------
// ds2411_id_check_if
// Handshake bundle between the DS2411 serial-number reader and its supervisor.
//   rd_go      : supervisor -> reader, request a ROM read
//   rd_working : reader -> supervisor, bus cycle in progress (reader clock domain)
//   rd_done    : reader -> supervisor, last cycle completed
//   rd_error   : reader -> supervisor, last cycle saw no presence / error
//   rd_result  : reader -> supervisor, 64-bit readback, wire bit k at [63-k]
// master = supervisor side, slave = reader side.
// ---------------------------------------------------------------------------
interface ds2411_id_check_if;
   logic        rd_go;
   logic        rd_working;
   logic        rd_done;
   logic        rd_error;
   logic [63:0] rd_result;

   modport master (
      output rd_go,
      input  rd_working,
      input  rd_done,
      input  rd_error,
      input  rd_result
   );

   modport slave (
      input  rd_go,
      output rd_working,
      output rd_done,
      output rd_error,
      output rd_result
   );
endinterface

// File: rtl/ds2411_id_check.sv
// ---------------------------------------------------------------------------
// ds2411_id_check
// Supervises one DS2411 ROM read: pulses the reader's go, waits for the bus
// cycle, retries on no-response or bad data, runs the Dallas CRC-8 over the
// 64-bit readback and reports a validated 48-bit board serial number.
//
// Optional feature: define DS2411_FAMILY_CHECK_EN to compare the family byte
// against FAMILY_CODE (mismatch -> fail_code 3). Undefined: no comparison.
//
// Ports
//   clk, reset    : 100 MHz clock, synchronous active-high reset
//   start         : one-cycle request, ignored while busy
//   rd            : reader handshake (master modport), inputs resynchronised
//   busy          : run in progress
//   id_valid      : sticky pass flag, cleared by start
//   id_fail       : sticky fail flag, cleared by start
//   fail_code     : 0 none, 1 no device/timeout, 2 CRC, 3 family
//   family/serial/crc_rx/crc_calc : fields of the last completed CRC pass
//   tries         : attempts used in the last run
// ---------------------------------------------------------------------------
module ds2411_id_check #(
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned GO_TIMEOUT  = 1000,
   parameter int unsigned RETRY_GAP   = 100000,
   parameter logic [7:0]  FAMILY_CODE = 8'h01
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   ds2411_id_check_if.master    rd,
   output logic                 busy,
   output logic                 id_valid,
   output logic                 id_fail,
   output logic [1:0]           fail_code,
   output logic [7:0]           family,
   output logic [47:0]          serial,
   output logic [7:0]           crc_rx,
   output logic [7:0]           crc_calc,
   output logic [3:0]           tries
);

   localparam int unsigned ROM_W    = 64;
   localparam int unsigned FAM_W    = 8;
   localparam int unsigned SER_W    = 48;
   localparam int unsigned CRC_W    = 8;
   localparam int unsigned TRY_W    = 4;
   localparam int unsigned SNAP_BIT = 55;
   localparam int unsigned LAST_BIT = ROM_W - 1;
   localparam int unsigned CNT_MAX  =
      (GO_TIMEOUT > RETRY_GAP) ? ((GO_TIMEOUT > ROM_W) ? GO_TIMEOUT : ROM_W)
                               : ((RETRY_GAP  > ROM_W) ? RETRY_GAP  : ROM_W);
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CRC_W-1:0] CRC_POLY = 8'h0C;

   localparam logic [1:0] CODE_NONE   = 2'd0;
   localparam logic [1:0] CODE_NORESP = 2'd1;
   localparam logic [1:0] CODE_CRC    = 2'd2;
`ifdef DS2411_FAMILY_CHECK_EN
   localparam logic [1:0] CODE_FAMILY = 2'd3;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_GO,
      S_WAIT,
      S_CHECK,
      S_CRC,
      S_EVAL,
      S_GAP,
      S_PASS,
      S_FAIL
   } state_e;

   state_e state_q, state_d;

   // Reader-domain inputs, two flops each
   logic [1:0] working_sync_q;
   logic [1:0] done_sync_q;
   logic [1:0] error_sync_q;
   logic       working_c;
   logic       done_c;
   logic       error_c;

   logic              rd_go_q,     rd_go_d;
   logic              busy_q,      busy_d;
   logic              id_valid_q,  id_valid_d;
   logic              id_fail_q,   id_fail_d;
   logic [1:0]        fail_code_q, fail_code_d;
   logic [TRY_W-1:0]  tries_q,     tries_d;
   logic [FAM_W-1:0]  family_q,    family_d;
   logic [SER_W-1:0]  serial_q,    serial_d;
   logic [CRC_W-1:0]  crc_rx_q,    crc_rx_d;
   logic [CRC_W-1:0]  crc_calc_q,  crc_calc_d;
   logic [CRC_W-1:0]  crc_q,       crc_d;
   logic [CRC_W-1:0]  crc_mid_q,   crc_mid_d;
   logic [ROM_W-1:0]  sr_q,        sr_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;

   logic              go_timeout_c;
   logic              gap_done_c;
   logic              crc_last_c;
   logic              crc_snap_c;
   logic              check_fail_c;
   logic [1:0]        eval_code_c;
   logic              attempt_fail_c;
   logic              attempt_end_c;
   logic [1:0]        attempt_code_c;
   logic              last_try_c;
   state_e            fail_dest_c;
   logic              crc_fb_c;
   logic [CRC_W-1:0]  crc_step_c;
   logic [ROM_W-1:0]  sr_rot_c;
   logic [ROM_W-1:0]  wire_word_c;

   // Reorders the shift register so index k holds wire bit k
   function automatic logic [ROM_W-1:0] bit_rev(input logic [ROM_W-1:0] x);
      logic [ROM_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(ROM_W); i++) begin
         r[i] = x[ROM_W-1-i];
      end
      return r;
   endfunction

   // Input synchronisers
   always_ff @(posedge clk) begin
      if (reset) begin
         working_sync_q <= '0;
         done_sync_q    <= '0;
         error_sync_q   <= '0;
      end else begin
         working_sync_q <= {working_sync_q[0], rd.rd_working};
         done_sync_q    <= {done_sync_q[0],    rd.rd_done};
         error_sync_q   <= {error_sync_q[0],   rd.rd_error};
      end
   end

   assign working_c = working_sync_q[1];
   assign done_c    = done_sync_q[1];
   assign error_c   = error_sync_q[1];

   // Shared cycle counter terminal counts
   assign go_timeout_c = (cnt_q == CNT_W'(GO_TIMEOUT - 1));
   assign gap_done_c   = (cnt_q == CNT_W'(RETRY_GAP - 1));
   assign crc_last_c   = (cnt_q == CNT_W'(LAST_BIT));
   assign crc_snap_c   = (cnt_q == CNT_W'(SNAP_BIT));

   // done and error together count as an error
   assign check_fail_c = error_c || !done_c;

   // CRC-8 (x^8+x^5+x^4+1, reflected), one wire bit per cycle from the MSB
   assign crc_fb_c   = sr_q[ROM_W-1] ^ crc_q[0];
   assign crc_step_c = {crc_fb_c, crc_q[CRC_W-1:1]} ^ (crc_fb_c ? CRC_POLY : CRC_W'(0));
   // Rotating keeps the original image after 64 shifts for field decode
   assign sr_rot_c    = {sr_q[ROM_W-2:0], sr_q[ROM_W-1]};
   assign wire_word_c = bit_rev(sr_rot_c);

   // A zero residual over all 64 bits means the received CRC matched
   always_comb begin
      eval_code_c = CODE_NONE;
      if (crc_q != CRC_W'(0)) begin
         eval_code_c = CODE_CRC;
      end
`ifdef DS2411_FAMILY_CHECK_EN
      else if (family_q != FAMILY_CODE) begin
         eval_code_c = CODE_FAMILY;
      end
`endif
   end

`ifndef DS2411_FAMILY_CHECK_EN
   // Family byte is still reported but never compared in this build
   logic unused_family_code;
   assign unused_family_code = ^FAMILY_CODE;
`endif

   assign attempt_fail_c = ((state_q == S_GO)    && !working_c && go_timeout_c) ||
                           ((state_q == S_CHECK) && check_fail_c) ||
                           ((state_q == S_EVAL)  && (eval_code_c != CODE_NONE));
   assign attempt_end_c  = attempt_fail_c || (state_q == S_EVAL);
   assign attempt_code_c = (state_q == S_EVAL) ? eval_code_c : CODE_NORESP;
   assign last_try_c     = ((5'(tries_q) + 5'd1) == 5'(MAX_TRIES));
   assign fail_dest_c    = last_try_c ? S_FAIL : S_GAP;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_GO;
         S_GO: begin
            // A reader still running from before a local reset is accepted
            if (working_c)         state_d = S_WAIT;
            else if (go_timeout_c) state_d = fail_dest_c;
         end
         S_WAIT:  if (!working_c) state_d = S_CHECK;
         S_CHECK: state_d = check_fail_c ? fail_dest_c : S_CRC;
         S_CRC:   if (crc_last_c) state_d = S_EVAL;
         S_EVAL:  state_d = (eval_code_c != CODE_NONE) ? fail_dest_c : S_PASS;
         S_GAP:   if (gap_done_c) state_d = S_GO;
         S_PASS:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      busy_d      = busy_q;
      id_valid_d  = id_valid_q;
      id_fail_d   = id_fail_q;
      fail_code_d = fail_code_q;
      tries_d     = tries_q;
      family_d    = family_q;
      serial_d    = serial_q;
      crc_rx_d    = crc_rx_q;
      crc_calc_d  = crc_calc_q;
      crc_d       = crc_q;
      crc_mid_d   = crc_mid_q;
      sr_d        = sr_q;
      rd_go_d     = (state_d == S_GO);
      cnt_d       = (state_d != state_q) ? CNT_W'(0) : cnt_q + CNT_W'(1);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d      = 1'b1;
               id_valid_d  = 1'b0;
               id_fail_d   = 1'b0;
               fail_code_d = CODE_NONE;
               tries_d     = TRY_W'(0);
            end
         end
         S_CHECK: begin
            if (!check_fail_c) begin
               sr_d  = rd.rd_result;
               crc_d = CRC_W'(0);
            end
         end
         S_CRC: begin
            crc_d = crc_step_c;
            sr_d  = sr_rot_c;
            // CRC over family + serial only, i.e. the value the ROM should carry
            if (crc_snap_c) crc_mid_d = crc_step_c;
            if (crc_last_c) begin
               family_d   = wire_word_c[FAM_W-1:0];
               serial_d   = wire_word_c[FAM_W+SER_W-1:FAM_W];
               crc_rx_d   = wire_word_c[ROM_W-1:FAM_W+SER_W];
               crc_calc_d = crc_mid_q;
            end
         end
         S_PASS: begin
            id_valid_d = 1'b1;
            busy_d     = 1'b0;
         end
         S_FAIL: begin
            id_fail_d = 1'b1;
            busy_d    = 1'b0;
         end
         default: ;
      endcase

      if (attempt_end_c) begin
         tries_d = tries_q + TRY_W'(1);
      end
      if (attempt_fail_c && last_try_c) begin
         fail_code_d = attempt_code_c;
      end
   end

   // Datapath / output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_go_q     <= 1'b0;
         busy_q      <= 1'b0;
         id_valid_q  <= 1'b0;
         id_fail_q   <= 1'b0;
         fail_code_q <= '0;
         tries_q     <= '0;
         family_q    <= '0;
         serial_q    <= '0;
         crc_rx_q    <= '0;
         crc_calc_q  <= '0;
         crc_q       <= '0;
         crc_mid_q   <= '0;
         sr_q        <= '0;
         cnt_q       <= '0;
      end else begin
         rd_go_q     <= rd_go_d;
         busy_q      <= busy_d;
         id_valid_q  <= id_valid_d;
         id_fail_q   <= id_fail_d;
         fail_code_q <= fail_code_d;
         tries_q     <= tries_d;
         family_q    <= family_d;
         serial_q    <= serial_d;
         crc_rx_q    <= crc_rx_d;
         crc_calc_q  <= crc_calc_d;
         crc_q       <= crc_d;
         crc_mid_q   <= crc_mid_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rd.rd_go  = rd_go_q;
   assign busy      = busy_q;
   assign id_valid  = id_valid_q;
   assign id_fail   = id_fail_q;
   assign fail_code = fail_code_q;
   assign tries     = tries_q;
   assign family    = family_q;
   assign serial    = serial_q;
   assign crc_rx    = crc_rx_q;
   assign crc_calc  = crc_calc_q;

endmodule

// File: tb/tb_ds2411_id_check.sv
// ---------------------------------------------------------------------------
// tb_ds2411_id_check
// Drives the supervisor through a behavioural DS2411 reader and checks every
// run against a reference model built from the Dallas CRC byte algorithm.
// ---------------------------------------------------------------------------
module tb_ds2411_id_check;

   localparam int unsigned MAX_TRIES   = 3;
   localparam int unsigned GO_TIMEOUT  = 20;
   localparam int unsigned RETRY_GAP   = 50;
   localparam logic [7:0]  FAMILY_CODE = 8'h02;
   localparam logic [63:0] GOOD_ROM    = 64'hA2000000_01B81C02;

   localparam int K_TIMEOUT = 0;
   localparam int K_ERROR   = 1;
   localparam int K_BOTH    = 2;
   localparam int K_NODONE  = 3;
   localparam int K_ROM     = 4;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        id_valid;
   logic        id_fail;
   logic [1:0]  fail_code;
   logic [7:0]  family;
   logic [47:0] serial;
   logic [7:0]  crc_rx;
   logic [7:0]  crc_calc;
   logic [3:0]  tries;

   ds2411_id_check_if rdr ();

   ds2411_id_check #(
      .MAX_TRIES   (MAX_TRIES),
      .GO_TIMEOUT  (GO_TIMEOUT),
      .RETRY_GAP   (RETRY_GAP),
      .FAMILY_CODE (FAMILY_CODE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rd        (rdr),
      .busy      (busy),
      .id_valid  (id_valid),
      .id_fail   (id_fail),
      .fail_code (fail_code),
      .family    (family),
      .serial    (serial),
      .crc_rx    (crc_rx),
      .crc_calc  (crc_calc),
      .tries     (tries)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Model state: per-attempt reader behaviour and last ROM that got a CRC pass
   int          att_kind [MAX_TRIES];
   logic [63:0] att_rom  [MAX_TRIES];
   logic [63:0] last_rom;

   // Byte-wise Dallas CRC over the low nbytes of v (byte 0 first)
   function automatic logic [7:0] dallas_crc(input logic [63:0] v, input int nbytes);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         b = v[8*i +: 8];
         c = c ^ b;
         for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
         end
      end
      return c;
   endfunction

   function automatic logic [63:0] make_rom(input logic [7:0] fam, input logic [47:0] ser);
      logic [63:0] v;
      v = {8'h00, ser, fam};
      v[63:56] = dallas_crc(v, 7);
      return v;
   endfunction

   function automatic logic [63:0] rev64(input logic [63:0] v);
      logic [63:0] r;
      r = {<<{v}};
      return r;
   endfunction

   function automatic int rom_code(input logic [63:0] v);
      if (dallas_crc(v, 7) != v[63:56]) return 2;
`ifdef DS2411_FAMILY_CHECK_EN
      if (v[7:0] != FAMILY_CODE) return 3;
`endif
      return 0;
   endfunction

   function automatic int attempt_code(input int a);
      if (att_kind[a] == K_ROM) return rom_code(att_rom[a]);
      return 1;
   endfunction

   // Expected outcome of one run; updates last_rom as each ROM is checked
   task automatic model_run(output logic m_valid, output logic m_fail,
                            output logic [1:0] m_code, output logic [3:0] m_tries);
      int code;
      m_valid = 1'b0;
      m_fail  = 1'b0;
      m_code  = 2'd0;
      m_tries = 4'd0;
      for (int a = 0; a < int'(MAX_TRIES); a++) begin
         code    = attempt_code(a);
         m_tries = 4'(a + 1);
         if (att_kind[a] == K_ROM) last_rom = att_rom[a];
         if (code == 0) begin
            m_valid = 1'b1;
            return;
         end
         if (a == int'(MAX_TRIES) - 1) begin
            m_fail = 1'b1;
            m_code = 2'(code);
         end
      end
   endtask

   task automatic set_all(input int kind, input logic [63:0] rom);
      for (int a = 0; a < int'(MAX_TRIES); a++) begin
         att_kind[a] = kind;
         att_rom[a]  = rom;
      end
   endtask

   // One complete run: start, serve each attempt as the reader would, check results
   task automatic run_case(input string name, input bit poke_start);
      logic       m_valid, m_fail;
      logic [1:0] m_code;
      logic [3:0] m_tries;
      int         n, hi;
      bit         prev_to;

      model_run(m_valid, m_fail, m_code, m_tries);

      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || rdr.rd_go !== 1'b1) begin
         miscompares++;
         $display("FAIL %s start_ack: busy=%b rd_go=%b, expected 1/1", name, busy, rdr.rd_go);
      end

      prev_to = 1'b0;
      for (int a = 0; a < int'(MAX_TRIES); a++) begin
         n = 0;
         while (rdr.rd_go !== 1'b1 && busy === 1'b1 && n < int'(RETRY_GAP + GO_TIMEOUT) + 200) begin
            @(posedge clk); #1; n++;
         end
         if (busy !== 1'b1) break;
         if (rdr.rd_go !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL %s go_wait: rd_go=%b after %0d cycles, expected 1", name, rdr.rd_go, n);
            break;
         end
         if (prev_to) begin
            vectors++;
            if (n != int'(RETRY_GAP)) begin
               miscompares++;
               $display("FAIL %s retry_gap: got %0d cycles, expected %0d", name, n, RETRY_GAP);
            end
         end

         if (att_kind[a] == K_TIMEOUT) begin
            hi = 0;
            while (rdr.rd_go === 1'b1 && hi < int'(GO_TIMEOUT) + 50) begin
               @(posedge clk); #1; hi++;
            end
            vectors++;
            if (hi != int'(GO_TIMEOUT)) begin
               miscompares++;
               $display("FAIL %s go_hold: rd_go high %0d cycles, expected %0d", name, hi, GO_TIMEOUT);
            end
            prev_to = 1'b1;
         end else begin
            prev_to = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rdr.rd_working = 1'b1;
            rdr.rd_done    = 1'b0;
            rdr.rd_error   = 1'b0;
            if (poke_start) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (rdr.rd_go === 1'b1 && n < 10) begin
               @(posedge clk); #1; n++;
            end
            vectors++;
            if (rdr.rd_go !== 1'b0) begin
               miscompares++;
               $display("FAIL %s go_drop: rd_go=%b, expected 0", name, rdr.rd_go);
            end
            rdr.rd_result = (att_kind[a] == K_ROM) ? rev64(att_rom[a]) : {$urandom, $urandom};
            rdr.rd_done   = (att_kind[a] == K_ROM || att_kind[a] == K_BOTH);
            rdr.rd_error  = (att_kind[a] == K_ERROR || att_kind[a] == K_BOTH);
            repeat (3) @(posedge clk);
            #1;
            rdr.rd_working = 1'b0;
            if (attempt_code(a) == 0) begin
               n = 0;
               do begin
                  @(posedge clk); #1; n++;
               end while (id_valid !== 1'b1 && n < 200);
               vectors++;
               if (n != 70 || busy !== 1'b0) begin
                  miscompares++;
                  $display("FAIL %s pass_latency: id_valid after %0d cycles busy=%b, expected 70 and 0",
                           name, n, busy);
               end
            end
         end
      end

      n = 0;
      while (busy !== 1'b0 && n < 500) begin
         @(posedge clk); #1; n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s end_wait: busy still %b", name, busy);
      end

      vectors++;
      if (id_valid !== m_valid || id_fail !== m_fail || fail_code !== m_code || tries !== m_tries) begin
         miscompares++;
         $display("FAIL %s status: valid=%b fail=%b code=%0d tries=%0d, expected %b %b %0d %0d",
                  name, id_valid, id_fail, fail_code, tries, m_valid, m_fail, m_code, m_tries);
      end
      vectors++;
      if (family !== last_rom[7:0] || serial !== last_rom[55:8] || crc_rx !== last_rom[63:56] ||
          crc_calc !== dallas_crc(last_rom, 7)) begin
         miscompares++;
         $display("FAIL %s fields: fam=%h ser=%h rx=%h calc=%h, expected %h %h %h %h",
                  name, family, serial, crc_rx, crc_calc, last_rom[7:0], last_rom[55:8],
                  last_rom[63:56], dallas_crc(last_rom, 7));
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [81:0] snap;
      snap = {busy, rdr.rd_go, id_valid, id_fail, fail_code, tries, family, serial, crc_rx, crc_calc};
      vectors++;
      if (snap !== 82'd0) begin
         miscompares++;
         $display("FAIL %s: outputs=%h, expected all zero", name, snap);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_hold");
      reset = 1'b0;
      @(posedge clk); #1;
      check_all_zero("reset_release");
   endtask

   task automatic test_good_rom();
      set_all(K_ROM, GOOD_ROM);
      run_case("good_rom", 1'b0);
      vectors++;
      if (serial !== 48'h0000_0001_B81C || crc_calc !== 8'hA2 || crc_rx !== 8'hA2 || family !== 8'h02) begin
         miscompares++;
         $display("FAIL good_rom_const: ser=%h calc=%h rx=%h fam=%h, expected 00000001b81c a2 a2 02",
                  serial, crc_calc, crc_rx, family);
      end
   endtask

   task automatic test_crc_error();
      set_all(K_ROM, GOOD_ROM ^ (64'd1 << 20));
      run_case("crc_error", 1'b0);
   endtask

   task automatic test_family();
      set_all(K_ROM, make_rom(8'h01, 48'h0000_0001_B81C));
      run_case("family", 1'b0);
   endtask

   task automatic test_retry();
      set_all(K_ROM, GOOD_ROM);
      att_kind[0] = K_ERROR;
      run_case("retry", 1'b0);
   endtask

   task automatic test_timeout();
      set_all(K_TIMEOUT, 64'd0);
      run_case("timeout", 1'b0);
   endtask

   task automatic test_last_try();
      set_all(K_ROM, GOOD_ROM);
      att_kind[0] = K_BOTH;
      att_kind[1] = K_NODONE;
      run_case("last_try", 1'b0);
   endtask

   task automatic test_busy_start();
      set_all(K_ROM, make_rom(FAMILY_CODE, 48'h1234_5678_9ABC));
      run_case("busy_start", 1'b1);
   endtask

   task automatic test_reset_mid_crc();
      int n;
      set_all(K_ROM, GOOD_ROM);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rdr.rd_working = 1'b1;
      rdr.rd_done    = 1'b0;
      rdr.rd_error   = 1'b0;
      n = 0;
      while (rdr.rd_go === 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      rdr.rd_result = rev64(GOOD_ROM);
      rdr.rd_done   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rdr.rd_working = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("reset_mid_crc");
      reset    = 1'b0;
      last_rom = 64'd0;
      // Reader keeps running across the local reset
      rdr.rd_working = 1'b1;
      run_case("reset_recover", 1'b0);
   endtask

   task automatic test_random();
      int          pick;
      logic [63:0] rom;
      logic [7:0]  fam;
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < int'(MAX_TRIES); a++) begin
            pick = int'($urandom_range(0, 9));
            fam  = ($urandom_range(0, 1) == 0) ? FAMILY_CODE : 8'($urandom);
            rom  = make_rom(fam, {16'($urandom), $urandom});
            if ($urandom_range(0, 3) == 0) rom = rom ^ (64'd1 << $urandom_range(0, 63));
            att_rom[a]  = rom;
            att_kind[a] = (pick < 4) ? pick : K_ROM;
         end
         run_case($sformatf("random_%0d", r), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      reset          = 1'b1;
      start          = 1'b0;
      rdr.rd_working = 1'b0;
      rdr.rd_done    = 1'b0;
      rdr.rd_error   = 1'b0;
      rdr.rd_result  = 64'd0;
      last_rom       = 64'd0;

      test_reset();
      test_good_rom();
      test_crc_error();
      test_family();
      test_retry();
      test_timeout();
      test_last_try();
      test_busy_start();
      test_reset_mid_crc();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
